// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM states
// and saturation bound helpers.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SUBI = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bounds returned 64 bits wide; callers keep the low w bits.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between decode, the ALU and writeback.
interface alu_mc_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, opcode, a, b, imm, out_ready,
        input  in_ready, out_valid, result, ovf, zero, neg, illegal, busy
    );

    modport slave (
        input  in_valid, opcode, a, b, imm, out_ready,
        output in_ready, out_valid, result, ovf, zero, neg, illegal, busy
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier for unsigned magnitudes, one multiplier bit
// per clock. The first bit is folded into the start cycle and the last bit is
// presented combinationally with done, so the product is ready WIDTH-1 clocks
// after start.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [2*WIDTH-1:0] src_acc, src_mcand;
    logic [WIDTH-1:0]   mplier_q, mplier_d, src_mplier;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;

    always_comb begin
        src_acc    = start ? '0 : acc_q;
        src_mcand  = start ? {{WIDTH{1'b0}}, mcand} : mcand_q;
        src_mplier = start ? mplier : mplier_q;
        product    = src_acc + (src_mplier[0] ? src_mcand : '0);
        done       = busy_q && (count_q == CW'(WIDTH - 1));

        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        busy_d   = busy_q;
        if (start || busy_q) begin
            acc_d    = product;
            mcand_d  = src_mcand << 1;
            mplier_d = src_mplier >> 1;
            count_d  = start ? CW'(1) : count_q + CW'(1);
            busy_d   = start || !done;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU between register read and writeback: single-cycle add/sub,
// iterative multiply, overflow/zero/negative flags and optional saturation.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input logic        clk,
    input logic        rst,
    alu_mc_if.slave    bus
);

    localparam logic [63:0]      SAT_MAX_W = sat_max(WIDTH);
    localparam logic [63:0]      SAT_MIN_W = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN_W[WIDTH-1:0];

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
    logic               illegal_q, illegal_d, sign_q, sign_d;

    logic               in_ready_c, accept, legal, is_sub;
    logic               as_ovf, mul_ovf, raw_ovf, true_neg;
    logic [WIDTH-1:0]   op2, addsub, abs_a, abs_imm, raw, final_res;
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product, mul_signed;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .mcand   (abs_a),
        .mplier  (abs_imm),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign in_ready_c = rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
    assign accept     = bus.in_valid && in_ready_c;

    // Datapath: the multiply result is only selected while finishing a MUL,
    // otherwise the add/sub path works on the live operands being accepted.
    always_comb begin
        legal   = (bus.opcode >= OP_ADD) && (bus.opcode <= OP_MUL);
        is_sub  = (bus.opcode == OP_SUB) || (bus.opcode == OP_SUBI);
        op2     = ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB)) ? bus.b : bus.imm;
        addsub  = is_sub ? (bus.a - op2) : (bus.a + op2);
        as_ovf  = (addsub[WIDTH-1] != bus.a[WIDTH-1]) &&
                  (is_sub ? (bus.a[WIDTH-1] != op2[WIDTH-1]) : (bus.a[WIDTH-1] == op2[WIDTH-1]));
        abs_a   = bus.a[WIDTH-1] ? -bus.a : bus.a;
        abs_imm = bus.imm[WIDTH-1] ? -bus.imm : bus.imm;

        mul_signed = sign_q ? -mul_product : mul_product;
        mul_ovf    = !((&mul_signed[2*WIDTH-1:WIDTH-1]) || !(|mul_signed[2*WIDTH-1:WIDTH-1]));

        if (state_q == ST_MUL) begin
            raw      = mul_signed[WIDTH-1:0];
            raw_ovf  = mul_ovf;
            true_neg = sign_q;
        end else begin
            raw      = addsub;
            raw_ovf  = as_ovf;
            true_neg = bus.a[WIDTH-1];
        end
        final_res = (SATURATE && raw_ovf) ? (true_neg ? SAT_MIN : SAT_MAX) : raw;
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        illegal_d = illegal_q;
        sign_d    = sign_q;
        mul_start = 1'b0;

        case (state_q)
            ST_MUL: begin
                if (mul_done) begin
                    result_d  = final_res;
                    ovf_d     = raw_ovf;
                    zero_d    = (final_res == '0);
                    neg_d     = final_res[WIDTH-1];
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Accept can fire from IDLE or from DONE in the handshake cycle.
        if (accept) begin
            if (bus.opcode == OP_MUL) begin
                mul_start = 1'b1;
                sign_d    = bus.a[WIDTH-1] ^ bus.imm[WIDTH-1];
                state_d   = ST_MUL;
            end else if (legal) begin
                result_d  = final_res;
                ovf_d     = raw_ovf;
                zero_d    = (final_res == '0);
                neg_d     = final_res[WIDTH-1];
                illegal_d = 1'b0;
                state_d   = ST_DONE;
            end else begin
                result_d  = '0;
                ovf_d     = 1'b0;
                zero_d    = 1'b1;
                neg_d     = 1'b0;
                illegal_d = 1'b1;
                state_d   = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            illegal_q <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            illegal_q <= illegal_d;
            sign_q    <= sign_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE) || mul_busy;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a wrapping and a saturating instance receive
// identical stimulus and are checked against a wide-integer reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
        logic         neg;
        logic         ill;
        int           acc_cycle;
        int           lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle       = 0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   firstCycle  = 0;
    bit   inBundle    = 1'b0;
    int   waited;

    alu_mc_if #(.WIDTH(W)) if0 ();
    alu_mc_if #(.WIDTH(W)) if1 ();

    alu_mc #(.WIDTH(W), .SATURATE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    alu_mc #(.WIDTH(W), .SATURATE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic signed [W-1:0] a,
                                   input logic signed [W-1:0] b, input logic signed [W-1:0] imm,
                                   input bit sat, input int acc);
        exp_t   e;
        longint full;
        longint maxv;
        longint minv;
        bit     legalOp;
        e       = '0;
        full    = 0;
        legalOp = 1'b1;
        maxv    = (longint'(1) <<< (W - 1)) - 1;
        minv    = -(longint'(1) <<< (W - 1));
        case (op)
            OP_ADD:  full = longint'(a) + longint'(b);
            OP_ADDI: full = longint'(a) + longint'(imm);
            OP_SUB:  full = longint'(a) - longint'(b);
            OP_SUBI: full = longint'(a) - longint'(imm);
            OP_MUL:  full = longint'(a) * longint'(imm);
            default: legalOp = 1'b0;
        endcase
        if (!legalOp) begin
            e.zero = 1'b1;
            e.ill  = 1'b1;
        end else begin
            e.ovf = (full > maxv) || (full < minv);
            if (sat && e.ovf) e.res = (full < 0) ? minv[W-1:0] : maxv[W-1:0];
            else              e.res = full[W-1:0];
            e.zero = (e.res == '0);
            e.neg  = e.res[W-1];
        end
        e.acc_cycle = acc;
        e.lat       = (op == OP_MUL) ? W : 1;
        return e;
    endfunction

    task automatic driveBus(input logic valid, input logic [2:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm);
        if0.in_valid = valid; if0.opcode = op; if0.a = a; if0.b = b; if0.imm = imm;
        if1.in_valid = valid; if1.opcode = op; if1.a = a; if1.b = b; if1.imm = imm;
    endtask

    task automatic setReady(input logic r);
        if0.out_ready = r;
        if1.out_ready = r;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] imm, output int nWait);
        nWait = 0;
        driveBus(1'b1, op, a, b, imm);
        #1;
        while (!if0.in_ready && nWait < 100) begin
            @(negedge clk);
            #1;
            nWait++;
        end
        checkOutput("in_ready_for_accept", if0.in_ready, 1'b1);
        if (if0.in_ready) begin
            q0.push_back(model(op, a, b, imm, 1'b0, cycle));
            q1.push_back(model(op, a, b, imm, 1'b1, cycle));
        end
        @(negedge clk);
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (q0.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_queue", q0.size(), 0);
    endtask

    // Scoreboard: compare each bundle as it is handed to the consumer.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            inBundle = 1'b0;
        end else begin
            if (if0.out_valid && !inBundle) begin
                firstCycle = cycle;
                inBundle   = 1'b1;
            end
            if (if0.out_valid && if0.out_ready) begin
                if (q0.size() == 0) begin
                    checkOutput("spurious_out_valid", if0.out_valid, 1'b0);
                end else begin
                    e0 = q0.pop_front();
                    e1 = q1.pop_front();
                    checkOutput("bundle_wrap", {if0.result, if0.ovf, if0.zero, if0.neg, if0.illegal},
                                {e0.res, e0.ovf, e0.zero, e0.neg, e0.ill});
                    checkOutput("bundle_sat", {if1.result, if1.ovf, if1.zero, if1.neg, if1.illegal},
                                {e1.res, e1.ovf, e1.zero, e1.neg, e1.ill});
                    checkOutput("latency", firstCycle - e0.acc_cycle, e0.lat);
                    checkOutput("sat_out_valid", if1.out_valid, 1'b1);
                end
                inBundle = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        driveBus(1'b0, 3'b000, '0, '0, '0);
        setReady(1'b1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs_wrap", {if0.in_ready, if0.out_valid, if0.result, if0.ovf, if0.zero,
                    if0.neg, if0.illegal, if0.busy}, '0);
        checkOutput("reset_outputs_sat", {if1.in_ready, if1.out_valid, if1.result, if1.ovf, if1.zero,
                    if1.neg, if1.illegal, if1.busy}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("in_ready_after_reset", if0.in_ready, 1'b1);
        @(negedge clk);

        // ADD then back-to-back SUBI
        applyStimulus(OP_ADD, 16'sd100, -16'sd30, '0, waited);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_SUBI, 16'(i * 1000), '0, 16'(i * 7 - 9), waited);
            checkOutput("b2b_wait", waited, 0);
        end
        driveBus(1'b0, 3'b000, '0, '0, '0);
        waitDrain();

        // MUL latency and in_ready low while multiplying
        applyStimulus(OP_MUL, -16'sd7, '0, 16'sd6, waited);
        driveBus(1'b0, 3'b000, '0, '0, '0);
        for (int i = 0; i < W - 1; i++) begin
            #1;
            checkOutput("mul_in_ready_low", if0.in_ready, 1'b0);
            checkOutput("mul_busy", if0.busy, 1'b1);
            @(negedge clk);
        end
        waitDrain();

        // Overflow corners, wrap vs saturate
        applyStimulus(OP_ADD, 16'sd32767, '0 + 16'sd1, '0, waited);
        applyStimulus(OP_SUB, 16'h8000, 16'sd1, '0, waited);
        applyStimulus(OP_MUL, 16'h8000, '0, 16'hFFFF, waited);
        driveBus(1'b0, 3'b000, '0, '0, '0);
        waitDrain();
        applyStimulus(OP_MUL, 16'sd300, '0, -16'sd200, waited);
        applyStimulus(OP_MUL, 16'sd0, '0, -16'sd5, waited);
        driveBus(1'b0, 3'b000, '0, '0, '0);
        waitDrain();

        // Random legal mix
        for (int i = 0; i < 20; i++) begin
            applyStimulus(3'($urandom_range(1, 5)), 16'($urandom), 16'($urandom), 16'($urandom), waited);
        end
        driveBus(1'b0, 3'b000, '0, '0, '0);
        waitDrain();

        // Backpressure hold, then same-cycle accept on release
        setReady(1'b0);
        applyStimulus(OP_ADD, 16'sd1234, 16'sd4321, '0, waited);
        driveBus(1'b1, OP_SUB, 16'sd500, 16'sd200, '0);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("hold_out_valid", if0.out_valid, 1'b1);
            checkOutput("hold_in_ready", if0.in_ready, 1'b0);
            checkOutput("hold_bundle", {if0.result, if0.ovf, if0.zero, if0.neg, if0.illegal},
                        {q0[0].res, q0[0].ovf, q0[0].zero, q0[0].neg, q0[0].ill});
            @(negedge clk);
        end
        setReady(1'b1);
        applyStimulus(OP_SUB, 16'sd500, 16'sd200, '0, waited);
        checkOutput("same_cycle_accept_wait", waited, 0);
        driveBus(1'b0, 3'b000, '0, '0, '0);
        waitDrain();

        // Illegal opcodes and a zero result
        applyStimulus(3'b111, 16'sd55, 16'sd66, 16'sd77, waited);
        applyStimulus(3'b000, -16'sd1, 16'sd2, 16'sd3, waited);
        applyStimulus(3'b110, 16'sd9, 16'sd9, 16'sd9, waited);
        applyStimulus(OP_SUB, '0, '0, '0, waited);
        driveBus(1'b0, 3'b000, '0, '0, '0);
        waitDrain();

        // Reset in the middle of a multiply
        applyStimulus(OP_MUL, 16'sd123, '0, 16'sd45, waited);
        driveBus(1'b0, 3'b000, '0, '0, '0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midmul_reset_wrap", {if0.in_ready, if0.out_valid, if0.result, if0.ovf, if0.zero,
                    if0.neg, if0.illegal, if0.busy}, '0);
        checkOutput("midmul_reset_sat", {if1.in_ready, if1.out_valid, if1.result, if1.ovf, if1.zero,
                    if1.neg, if1.illegal, if1.busy}, '0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            #1;
            checkOutput("no_out_valid_after_reset", if0.out_valid, 1'b0);
        end
        @(negedge clk);
        applyStimulus(OP_ADD, 16'sd20, 16'sd22, '0, waited);
        driveBus(1'b0, 3'b000, '0, '0, '0);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
